// File: rtl/fnd_pkg.sv
// fnd_pkg: shared types and constants for the FND scan path. Rev 1.0
`default_nettype none

package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_t;

  localparam int NUM_DIGITS  = 4;
  localparam int VALUE_W     = 14;
  localparam int BCD_W       = 4 * NUM_DIGITS;
  localparam int MAX_DISPLAY = 9999;
  localparam logic [BCD_W-1:0] SAT_BCD = {NUM_DIGITS{4'd9}};

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 14-bit shift-add-3 converter with saturation. Rev 1.0
`default_nettype none

module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [VALUE_W-1:0] i_value,
  output logic               o_busy,
  output logic               o_done,
  output logic [BCD_W-1:0]   o_bcd,
  output logic               o_overflow
);

  conv_state_t        state_q, state_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [VALUE_W-1:0] val_q, val_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [3:0]         iter_q, iter_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   adj;
  logic               val_over;

  assign val_over = (val_q > VALUE_W'(MAX_DISPLAY));

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    adj     = add3_nibbles(bcd_q);
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          bin_d   = i_value;
          val_d   = i_value;
          bcd_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d  = {adj[BCD_W-2:0], bin_q[VALUE_W-1]};
        bin_d  = {bin_q[VALUE_W-2:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'(VALUE_W - 1)) begin
          state_d = ST_LOAD;
          done_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        ovf_d   = val_over;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      val_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overflow = ovf_q;
  // Out-of-range inputs present as all nines rather than a truncated accumulator.
  assign o_bcd      = val_over ? SAT_BCD : bcd_q;

endmodule

`default_nettype wire

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: binary-to-BCD conversion plus 4-digit FND scan with blanking. Rev 1.0
`default_nettype none

module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_update,
  output logic [1:0]         o_digitSelect,
  output logic [3:0]         o_bcd,
  output logic               o_en,
  output logic               o_busy,
  output logic               o_overflow
);

  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [1:0]            sel_q, sel_d;
  logic [BCD_W-1:0]      disp_q, disp_d;
  logic                  conv_done;
  logic [BCD_W-1:0]      conv_bcd;
  logic                  pre_wrap;
  logic [NUM_DIGITS-1:0] digit_nz;
  logic                  en;

  bin2bcd_seq u_conv (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_start    (i_update),
    .i_value    (i_value),
    .o_busy     (o_busy),
    .o_done     (conv_done),
    .o_bcd      (conv_bcd),
    .o_overflow (o_overflow)
  );

  assign pre_wrap = (pre_q == PRE_W'(SCAN_DIV - 1));

  always_comb begin
    pre_d  = pre_wrap ? '0 : pre_q + 1'b1;
    sel_d  = pre_wrap ? sel_q + 2'd1 : sel_q;
    disp_d = conv_done ? conv_bcd : disp_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_q  <= '0;
      sel_q  <= '0;
      disp_q <= '0;
    end else begin
      pre_q  <= pre_d;
      sel_q  <= sel_d;
      disp_q <= disp_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit_nz
      assign digit_nz[g] = |disp_q[4*g +: 4];
    end
  endgenerate

  // A digit is lit if it or any more significant digit is non-zero; the ones digit always is.
  always_comb begin
    en = (sel_q == 2'd0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_nz[i] && (i >= int'(sel_q))) en = 1'b1;
    end
  end

  assign o_digitSelect = sel_q;
  assign o_bcd         = disp_q[{sel_q, 2'b00} +: 4];
  assign o_en          = en;

endmodule

`default_nettype wire

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Upstream driver for the 4-digit FND path. It takes a 14-bit binary result, converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes those digits. Its outputs `o_digitSelect`, `o_bcd` and `o_en` connect directly to the digit-select, value and enable inputs of the BCD-to-FND decoder. This replaces the externally driven digit select, so a multi-digit result scans automatically on the board.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ 2.
- `i_clk`  in  1  system clock; all state changes on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_value`  in  14  unsigned binary value to display; valid range 0..9999.
- `i_update`  in  1  single-cycle strobe; sample `i_value` and start conversion.
- `o_digitSelect`  out  2  digit currently scanned; 0 = ones, 3 = thousands.
- `o_bcd`  out  4  BCD digit for the selected position.
- `o_en`  out  1  decoder enable; 0 blanks the selected digit (leading-zero suppression).
- `o_busy`  out  1  conversion in progress.
- `o_overflow`  out  1  last accepted value was > 9999.

## Operation
- **Conversion FSM states:** IDLE, SHIFT, LOAD.
- **IDLE, `i_update`=1:**
  - Latch `i_value` into the shift register.
  - Clear the 16-bit BCD accumulator and the iteration counter.
  - Go to SHIFT.
- **IDLE, `i_update`=0:** stay in IDLE.
- **SHIFT, one iteration per cycle:**
  - For each BCD nibble ≥ 5, add 3.
  - Shift {BCD, binary} left by 1.
  - After 14 iterations, go to LOAD.
- **LOAD:**
  - Copy the accumulator into the 4×4-bit display register.
  - Set `o_overflow` = (latched value > 9999).
  - Return to IDLE.
- **Overflow:** if the latched value is > 9999, the display register is loaded with 9,9,9,9 (saturated) instead of the accumulator.
- **`o_busy`:** 1 in SHIFT and LOAD, 0 in IDLE.
- **`i_update` while busy:** ignored. No queuing and no restart.
- **Scan prescaler:**
  - Free-running counter 0..SCAN_DIV-1, width $clog2(SCAN_DIV).
  - At terminal count it wraps to 0 and `o_digitSelect` increments modulo 4 (3 → 0).
- **Scan independence:** scanning runs continuously and is independent of the conversion FSM. The display register changes only in LOAD.
- **`o_bcd`:** the display-register nibble indexed by `o_digitSelect`. It is a mux of registers, so it has no combinational path from `i_value`.
- **`o_en` (leading-zero suppression):**
  - `o_en` = 0 when the selected digit and every higher digit are zero.
  - Digit 0 always has `o_en` = 1, so a value of 0 shows a single "0".

## Timing
- **Reset values:**
  - `o_digitSelect`=0, `o_bcd`=0, `o_en`=1.
  - `o_busy`=0, `o_overflow`=0.
  - Display register all zero, prescaler 0, FSM in IDLE.
- **Latency:**
  - `i_update` is sampled at edge 0.
  - `o_busy`=1 from edge 0 through edge 15.
  - The display register and `o_overflow` update at edge 15 (LOAD).
  - New `o_bcd` is visible after edge 15.
  - Total: 16 cycles from strobe to display.
- **Back-to-back updates:** the next `i_update` is accepted at the edge after `o_busy` falls, i.e. one accepted strobe per 16 cycles maximum.
- **Display update vs. scan step:** if LOAD coincides with a prescaler wrap, both take effect on the same edge. The new digit select indexes the new display contents.
- **Reset asserted mid-conversion:**
  - Immediate return to the reset values.
  - The partial result is discarded and the display is not updated.
- **`i_value` after the strobe:** don't-care.

## Structure
- **Shared package `fnd_pkg`:**
  - Conversion state enum (IDLE, SHIFT, LOAD).
  - `NUM_DIGITS`=4.
  - `VALUE_W`=14.
  - `MAX_DISPLAY`=9999.
- **Sub-module `bin2bcd_seq`:**
  - Contains the shift-add-3 engine and its FSM.
  - Ports: clock, reset, start, 14-bit value, busy, done pulse, 16-bit BCD, overflow.
- **Top level:** owns the prescaler, digit counter, display register, output mux and blanking logic.

## Test plan
All scenarios use SCAN_DIV=4.
- **Reset:** assert `i_reset_n`=0 mid-run → all outputs at reset values; `o_digitSelect` holds 0 until 4 cycles after release.
- **Conversion 1234:** `i_update` with `i_value`=1234 → `o_busy` high for exactly 16 cycles. Then the scan shows digitSelect 0..3 → `o_bcd` 4,3,2,1 with `o_en`=1 on every digit.
- **Leading-zero blanking:**
  - `i_value`=7 → digit0 shows `o_bcd`=7 with `o_en`=1; digits 1-3 have `o_en`=0.
  - `i_value`=0 → only digit0 is enabled and shows 0.
  - `i_value`=1005 → all four digits enabled, showing 5,0,0,1.
- **Overflow:** `i_value`=12000 → `o_overflow`=1 and the display shows 9,9,9,9. A following update with `i_value`=9999 → `o_overflow`=0.
- **Update while busy:** strobe 42, then strobe 99 three cycles later → the second strobe is ignored and the display shows 42 after 16 cycles.
- **Reset mid-conversion:** strobe 4321, assert reset at cycle 8, release → display stays 0 and `o_busy`=0. A new strobe with 4321 then converts correctly.
